pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall / flush / redirect controller for an in-order pipeline, with
// per-stage statistics counters and a stall watchdog.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   hold            : per-stage "cannot advance" request
//   redir_valid     : per-stage redirect request
//   redir_target    : per-stage redirect target, slice i belongs to stage i
//   stall, flush    : per pipeline input register (index 0 = PC register)
//   load_pc_we      : PC overload strobe
//   load_pc_new_pc  : PC overload value (target of the winning redirect)
//   cnt_sel         : statistics counter select (registered readout)
//   cnt_clear       : synchronous clear of all counters and the watchdog
//   cnt_data        : selected counter, one cycle after cnt_sel
//   wd_trip         : sticky watchdog flag, cleared only by cnt_clear
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16,
  parameter int WD_LIMIT   = 1024,
  parameter int DELAY_SLOT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_STAGES-1:0]      hold,
  input  logic [NUM_STAGES-1:0]      redir_valid,
  input  logic [NUM_STAGES*PC_W-1:0] redir_target,
  output logic [NUM_STAGES-1:0]      stall,
  output logic [NUM_STAGES-1:0]      flush,
  output logic                       load_pc_we,
  output logic [PC_W-1:0]            load_pc_new_pc,
  input  logic [4:0]                 cnt_sel,
  input  logic                       cnt_clear,
  output logic [CNT_W-1:0]           cnt_data,
  output logic                       wd_trip
);

  // Delay slot is a single-instruction concept; any non-zero value means one.
  localparam int DS   = (DELAY_SLOT != 0) ? 1 : 0;
  localparam int WD_W = $clog2(WD_LIMIT) + 1;

  typedef enum logic [1:0] {
    WD_IDLE  = 2'd0,
    WD_COUNT = 2'd1,
    WD_TRIP  = 2'd2
  } wd_state_t;

  // Saturating increment: a full counter stays full instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    sat_inc = (en && (v != {CNT_W{1'b1}})) ? (v + CNT_W'(1)) : v;
  endfunction

  logic [NUM_STAGES:0]   stalled_raw_s;  // bit NUM_STAGES is the writeback side, never stalled
  logic [NUM_STAGES-1:0] cand_s;
  logic [NUM_STAGES-1:0] win_oh_s;
  logic                  win_any_s;
  logic [NUM_STAGES:0]   le_win_s;       // bit j set when j <= winner index
  logic [NUM_STAGES-1:0] lt_win_s;
  logic [NUM_STAGES-1:0] killed_s;
  logic [NUM_STAGES-1:0] hold_eff_s;
  logic [NUM_STAGES-1:0] stalled_eff_s;
  logic [PC_W-1:0]       new_pc_s;
  logic                  found_s;
  logic                  acc_s;

  logic [CNT_W-1:0]      hc_r [NUM_STAGES];
  logic [CNT_W-1:0]      he_r [NUM_STAGES];
  logic [CNT_W-1:0]      rd_r [NUM_STAGES];
  logic [NUM_STAGES-1:0] hold_q_r;
  logic                  armed_r;
  logic [NUM_STAGES-1:0] hold_rise_s;
  logic [CNT_W-1:0]      sel_val_s;
  logic [CNT_W-1:0]      cnt_data_r;

  wd_state_t             wd_state_r;
  wd_state_t             wd_state_n;
  logic [WD_W-1:0]       wd_cnt_r;
  logic [WD_W-1:0]       wd_cnt_n;
  logic                  wd_trip_r;

  // Stall propagation: a held stage also blocks everything older than it.
  always_comb begin
    stalled_raw_s = {(NUM_STAGES+1){1'b0}};
    for (int i = NUM_STAGES-1; i >= 0; i--) begin
      stalled_raw_s[i] = hold[i] | stalled_raw_s[i+1];
    end
  end

  // Redirect arbitration: the oldest (highest index) unblocked request wins.
  always_comb begin
    found_s   = 1'b0;
    cand_s    = {NUM_STAGES{1'b0}};
    win_oh_s  = {NUM_STAGES{1'b0}};
    for (int i = NUM_STAGES-1; i >= 0; i--) begin
      cand_s[i]   = redir_valid[i] & ~stalled_raw_s[i+1];
      win_oh_s[i] = cand_s[i] & ~found_s;
      found_s     = found_s | cand_s[i];
    end
    win_any_s = found_s;
  end

  // Winner-relative masks and the effective stall/flush vectors.
  always_comb begin
    acc_s         = 1'b0;
    le_win_s      = {(NUM_STAGES+1){1'b0}};
    lt_win_s      = {NUM_STAGES{1'b0}};
    killed_s      = {NUM_STAGES{1'b0}};
    hold_eff_s    = {NUM_STAGES{1'b0}};
    stalled_eff_s = {NUM_STAGES{1'b0}};
    new_pc_s      = {PC_W{1'b0}};
    for (int j = NUM_STAGES-1; j >= 0; j--) begin
      acc_s       = acc_s | win_oh_s[j];
      le_win_s[j] = acc_s;
      lt_win_s[j] = acc_s & ~win_oh_s[j];
    end
    // Registers 1..r-DS hold instructions on the wrong path.
    for (int j = 1; j < NUM_STAGES; j++) begin
      killed_s[j] = le_win_s[j+DS];
    end
    hold_eff_s = hold & ~lt_win_s;
    // A winner only exists when everything downstream of it is free, so the
    // stages at and above the winner become unstalled.
    for (int j = 0; j < NUM_STAGES; j++) begin
      stalled_eff_s[j] = stalled_raw_s[j] & ~le_win_s[j];
      new_pc_s         = new_pc_s | ({PC_W{win_oh_s[j]}} & redir_target[j*PC_W +: PC_W]);
    end
  end

  // Combinational control outputs; a held stage pushes a bubble forward.
  always_comb begin
    stall    = stalled_eff_s;
    flush    = {NUM_STAGES{1'b0}};
    for (int i = 1; i < NUM_STAGES; i++) begin
      flush[i] = killed_s[i] | (hold_eff_s[i-1] & ~stalled_eff_s[i]);
    end
    load_pc_we     = win_any_s;
    load_pc_new_pc = new_pc_s;
  end

  // Rising-edge detect; armed_r suppresses a hold that was already high at reset release.
  assign hold_rise_s = hold & ~hold_q_r & {NUM_STAGES{armed_r}};

  // Registered hold copy for event counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q_r <= {NUM_STAGES{1'b0}};
      armed_r  <= 1'b0;
    end else begin
      hold_q_r <= hold;
      armed_r  <= 1'b1;
    end
  end

  // Statistics counters: hold cycles, hold events, redirect wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        hc_r[i] <= {CNT_W{1'b0}};
        he_r[i] <= {CNT_W{1'b0}};
        rd_r[i] <= {CNT_W{1'b0}};
      end
    end else if (cnt_clear) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        hc_r[i] <= {CNT_W{1'b0}};
        he_r[i] <= {CNT_W{1'b0}};
        rd_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        hc_r[i] <= sat_inc(hc_r[i], hold[i]);
        he_r[i] <= sat_inc(he_r[i], hold_rise_s[i]);
        rd_r[i] <= sat_inc(rd_r[i], win_oh_s[i]);
      end
    end
  end

  // Counter readout mux; unmapped selects fall through to zero.
  always_comb begin
    sel_val_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      sel_val_s = sel_val_s
                | ({CNT_W{cnt_sel == 5'(i)}}      & hc_r[i])
                | ({CNT_W{cnt_sel == 5'(8 + i)}}  & he_r[i])
                | ({CNT_W{cnt_sel == 5'(16 + i)}} & rd_r[i]);
    end
  end

  // Readout register, the only path from cnt_sel to an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_data_r <= {CNT_W{1'b0}};
    end else if (cnt_clear) begin
      cnt_data_r <= {CNT_W{1'b0}};
    end else begin
      cnt_data_r <= sel_val_s;
    end
  end

  assign cnt_data = cnt_data_r;

  // Watchdog next state: counts consecutive cycles with the PC register stalled.
  always_comb begin
    wd_state_n = wd_state_r;
    wd_cnt_n   = wd_cnt_r;
    case (wd_state_r)
      WD_IDLE: begin
        if (stalled_eff_s[0]) begin
          wd_state_n = WD_COUNT;
          wd_cnt_n   = WD_W'(1);
        end else begin
          wd_cnt_n   = {WD_W{1'b0}};
        end
      end
      WD_COUNT: begin
        if (!stalled_eff_s[0]) begin
          wd_state_n = WD_IDLE;
          wd_cnt_n   = {WD_W{1'b0}};
        end else if (wd_cnt_r >= WD_W'(WD_LIMIT - 1)) begin
          wd_state_n = WD_TRIP;
        end else begin
          wd_cnt_n   = wd_cnt_r + WD_W'(1);
        end
      end
      WD_TRIP: begin
        wd_state_n = WD_TRIP;
      end
      default: begin
        wd_state_n = WD_IDLE;
        wd_cnt_n   = {WD_W{1'b0}};
      end
    endcase
    if (cnt_clear) begin
      wd_state_n = WD_IDLE;
      wd_cnt_n   = {WD_W{1'b0}};
    end else begin
      wd_cnt_n   = wd_cnt_n;
    end
  end

  // Watchdog state register and registered trip flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_state_r <= WD_IDLE;
      wd_cnt_r   <= {WD_W{1'b0}};
      wd_trip_r  <= 1'b0;
    end else begin
      wd_state_r <= wd_state_n;
      wd_cnt_r   <= wd_cnt_n;
      wd_trip_r  <= (wd_state_n == WD_TRIP);
    end
  end

  assign wd_trip = wd_trip_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int NS    = 5;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NS-1:0]        hold;
  logic [NS-1:0]        redir_valid;
  logic [NS*PC_W-1:0]   redir_target;
  logic [NS-1:0]        stall;
  logic [NS-1:0]        flush;
  logic                 load_pc_we;
  logic [PC_W-1:0]      load_pc_new_pc;
  logic [4:0]           cnt_sel;
  logic                 cnt_clear;
  logic [CNT_W-1:0]     cnt_data;
  logic                 wd_trip;

  int checks;
  int errors;

  pipe_hazard_ctrl #(
    .NUM_STAGES(NS), .PC_W(PC_W), .CNT_W(CNT_W), .WD_LIMIT(8), .DELAY_SLOT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .redir_valid(redir_valid),
    .redir_target(redir_target), .stall(stall), .flush(flush),
    .load_pc_we(load_pc_we), .load_pc_new_pc(load_pc_new_pc),
    .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_data(cnt_data), .wd_trip(wd_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  hold;
    logic [4:0]  rv;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        we;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
  endtask

  task automatic read_cnt(input logic [4:0] sel, input logic [31:0] exp, input string name);
    cnt_sel = sel;
    tick();
    check(name, 32'(cnt_data), exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    hold = 5'b00000;
    redir_valid = 5'b00000;
    cnt_sel = 5'd0;
    cnt_clear = 1'b0;
    for (int i = 0; i < NS; i++) redir_target[i*PC_W +: PC_W] = 32'((i + 1) * 32'h100);

    //            hold      rv        stall     flush     we    pc
    vecs[0]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 32'h0};
    vecs[1]  = '{5'b00100, 5'b00000, 5'b00111, 5'b01000, 1'b0, 32'h0};
    vecs[2]  = '{5'b00001, 5'b01000, 5'b00000, 5'b00110, 1'b1, 32'h400};
    vecs[3]  = '{5'b00000, 5'b01010, 5'b00000, 5'b00110, 1'b1, 32'h400};
    vecs[4]  = '{5'b10000, 5'b00100, 5'b11111, 5'b00000, 1'b0, 32'h0};
    vecs[5]  = '{5'b10000, 5'b00000, 5'b11111, 5'b00000, 1'b0, 32'h0};
    vecs[6]  = '{5'b01000, 5'b00100, 5'b01111, 5'b10000, 1'b0, 32'h0};
    vecs[7]  = '{5'b01000, 5'b10010, 5'b00000, 5'b01110, 1'b1, 32'h500};
    vecs[8]  = '{5'b00000, 5'b00010, 5'b00000, 5'b00000, 1'b1, 32'h200};
    vecs[9]  = '{5'b00011, 5'b00000, 5'b00011, 5'b00100, 1'b0, 32'h0};
    vecs[10] = '{5'b10101, 5'b00000, 5'b11111, 5'b00000, 1'b0, 32'h0};
    vecs[11] = '{5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b1, 32'h100};
    vecs[12] = '{5'b00110, 5'b01000, 5'b00000, 5'b00110, 1'b1, 32'h400};

    // Reset state; combinational outputs follow inputs during reset.
    hold = 5'b00100;
    #12;
    check("rst_cnt_data", 32'(cnt_data), 32'h0);
    check("rst_wd_trip", 32'(wd_trip), 32'h0);
    check("rst_stall", 32'(stall), 32'h07);
    check("rst_flush", 32'(flush), 32'h08);
    hold = 5'b00000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Combinational vector table.
    for (int v = 0; v < 13; v++) begin
      hold = vecs[v].hold;
      redir_valid = vecs[v].rv;
      #1;
      check($sformatf("vec%0d_stall", v), 32'(stall), 32'(vecs[v].stall));
      check($sformatf("vec%0d_flush", v), 32'(flush), 32'(vecs[v].flush));
      check($sformatf("vec%0d_we", v), 32'(load_pc_we), 32'(vecs[v].we));
      check($sformatf("vec%0d_pc", v), load_pc_new_pc, vecs[v].pc);
      tick();
    end
    hold = 5'b00000;
    redir_valid = 5'b00000;

    // Hold counters on stage 2 over 10 cycles.
    clear_all();
    hold = 5'b00100;
    repeat (10) tick();
    hold = 5'b00000;
    read_cnt(5'd2, 32'd10, "hold_cycle2");
    read_cnt(5'd10, 32'd1, "hold_event2");
    read_cnt(5'd1, 32'd0, "hold_cycle1");
    read_cnt(5'd26, 32'd0, "sel26_zero");
    read_cnt(5'd5, 32'd0, "sel5_zero");

    // Clear coinciding with an increment: clear wins.
    hold = 5'b00100;
    clear_all();
    hold = 5'b00000;
    check("clear_wd_trip", 32'(wd_trip), 32'h0);
    read_cnt(5'd2, 32'd0, "clear_win_hc2");
    read_cnt(5'd10, 32'd0, "clear_win_he2");

    // Redirect arbitration counters.
    redir_valid = 5'b01010;
    tick();
    redir_valid = 5'b00000;
    read_cnt(5'd19, 32'd1, "redirect3");
    read_cnt(5'd17, 32'd0, "redirect1");

    // Watchdog: near miss of 7 stalled cycles does not trip.
    clear_all();
    hold = 5'b10000;
    repeat (7) tick();
    hold = 5'b00000;
    tick();
    tick();
    check("wd_near_miss", 32'(wd_trip), 32'h0);

    // Watchdog: 8 stalled cycles trip on the 8th edge, sticky until clear.
    hold = 5'b10000;
    repeat (7) tick();
    check("wd_edge7", 32'(wd_trip), 32'h0);
    tick();
    check("wd_edge8", 32'(wd_trip), 32'h1);
    hold = 5'b00000;
    repeat (3) tick();
    check("wd_sticky", 32'(wd_trip), 32'h1);
    clear_all();
    check("wd_cleared", 32'(wd_trip), 32'h0);

    // Saturation at 15, then asynchronous reset mid-cycle.
    clear_all();
    hold = 5'b00010;
    repeat (20) tick();
    read_cnt(5'd1, 32'd15, "hc1_saturate");
    read_cnt(5'd9, 32'd1, "he1_before_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt_data", 32'(cnt_data), 32'h0);
    check("async_rst_stall", 32'(stall), 32'h03);
    cnt_sel = 5'd9;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_he1_a", 32'(cnt_data), 32'h0);
    tick();
    check("post_rst_he1_b", 32'(cnt_data), 32'h0);
    read_cnt(5'd1, 32'd2, "post_rst_hc1");
    hold = 5'b00000;
    tick();
    hold = 5'b00010;
    tick();
    hold = 5'b00000;
    read_cnt(5'd9, 32'd1, "post_rst_he1_edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
